// File: rtl/pwm_core.sv
// Single-channel PWM core: prescaler, period counter, and double-buffered
// period/duty/prescale registers that only change at a period boundary.
module pwm_core #(
    parameter int WIDTH = 8,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [PW-1:0]    presc_in,
    output logic             pwm_out,
    output logic             period_end,
    output logic             pending,
    output logic [WIDTH-1:0] cnt_out
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [PW-1:0]    PRE_ONE = PW'(1);

    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
    logic [PW-1:0]    presc_a_q, presc_a_d;
    logic [WIDTH-1:0] per_s_q, per_s_d, duty_s_q, duty_s_d;
    logic [PW-1:0]    presc_s_q, presc_s_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             period_end_q, period_end_d;
    logic             tick, wrap;

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        per_a_d      = per_a_q;
        duty_a_d     = duty_a_q;
        presc_a_d    = presc_a_q;
        per_s_d      = per_s_q;
        duty_s_d     = duty_s_q;
        presc_s_d    = presc_s_q;
        pending_d    = pending_q;

        tick = en && (pre_cnt_q == presc_a_q);
        wrap = tick && (cnt_q == per_a_q);

        if (!en) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            cnt_d     = wrap ? '0 : cnt_q + CNT_ONE;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
        end

        period_end_d = wrap;
        pwm_d        = en && (cnt_q < duty_a_q);

        // While running, the wrap consumes the shadow as it stood before this
        // cycle; a coincident load refills it and stays pending for next wrap.
        if (en) begin
            if (wrap && pending_q) begin
                per_a_d   = per_s_q;
                duty_a_d  = duty_s_q;
                presc_a_d = presc_s_q;
                pending_d = 1'b0;
            end
            if (load) begin
                per_s_d   = period_in;
                duty_s_d  = duty_in;
                presc_s_d = presc_in;
                pending_d = 1'b1;
            end
        end else begin
            if (load) begin
                per_s_d   = period_in;
                duty_s_d  = duty_in;
                presc_s_d = presc_in;
                per_a_d   = period_in;
                duty_a_d  = duty_in;
                presc_a_d = presc_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                per_a_d   = per_s_q;
                duty_a_d  = duty_s_q;
                presc_a_d = presc_s_q;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            per_a_q      <= '0;
            duty_a_q     <= '0;
            presc_a_q    <= '0;
            per_s_q      <= '0;
            duty_s_q     <= '0;
            presc_s_q    <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            per_a_q      <= per_a_d;
            duty_a_q     <= duty_a_d;
            presc_a_q    <= presc_a_d;
            per_s_q      <= per_s_d;
            duty_s_q     <= duty_s_d;
            presc_s_q    <= presc_s_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;
    assign pending    = pending_q;
    assign cnt_out    = cnt_q;

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: each expected period (length, high clocks)
// is queued by the stimulus and checked by a monitor on every period_end.
module tb_pwm_core;

    localparam int WIDTH = 8;
    localparam int PW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] period_in;
    logic [WIDTH-1:0] duty_in;
    logic [PW-1:0]    presc_in;
    logic             pwm_out;
    logic             period_end;
    logic             pending;
    logic [WIDTH-1:0] cnt_out;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_len[$];
    int exp_hi[$];

    pwm_core #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .presc_in   (presc_in),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .pending    (pending),
        .cnt_out    (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            load = 1'b0;
        end
    endtask

    task automatic start_load(input int p, input int d, input int s);
        period_in = WIDTH'(p);
        duty_in   = WIDTH'(d);
        presc_in  = PW'(s);
        load      = 1'b1;
    endtask

    task automatic push_periods(input int len, input int hi, input int count);
        for (int i = 0; i < count; i++) begin
            exp_len.push_back(len);
            exp_hi.push_back(hi);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_len.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (exp_len.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d periods still outstanding, required 0", exp_len.size());
            exp_len.delete();
            exp_hi.delete();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0;
        period_in = '0; duty_in = '0; presc_in = '0;
        fork
            begin : monitor
                int len, hi, el, eh;
                logic en_prev;
                len = 0; hi = 0; en_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst || !en_prev) begin
                        len = 0;
                        hi  = 0;
                    end else begin
                        len++;
                        if (pwm_out) hi++;
                        if (period_end) begin
                            if (exp_len.size() == 0) begin
                                n_checks++;
                                $display("FAIL unexpected_period: len %0d hi %0d, required none", len, hi);
                            end else begin
                                el = exp_len.pop_front();
                                eh = exp_hi.pop_front();
                                check("period_len", len, el);
                                check("period_high", hi, eh);
                            end
                            len = 0;
                            hi  = 0;
                        end
                    end
                    en_prev = en;
                end
            end
            begin : stimulus
                // reset state
                step_n(2);
                check("rst_pwm", int'(pwm_out), 0);
                check("rst_period_end", int'(period_end), 0);
                check("rst_pending", int'(pending), 0);
                check("rst_cnt", int'(cnt_out), 0);
                rst = 1'b0;
                step_n(1);

                // basic 1,1,0,0 waveform
                start_load(3, 2, 0);
                step_n(1);
                check("direct_load_pending", int'(pending), 0);
                push_periods(4, 2, 3);
                en = 1'b1;
                wait_drain(100);
                en = 1'b0;
                step_n(2);

                // mid-period duty change takes effect at the wrap
                start_load(9, 5, 0);
                step_n(1);
                push_periods(10, 5, 1);
                push_periods(10, 7, 2);
                en = 1'b1;
                step_n(2);
                start_load(9, 7, 0);
                step_n(1);
                check("load_pending", int'(pending), 1);
                check("load_cnt3", int'(cnt_out), 3);
                step_n(6);
                check("pre_wrap_cnt", int'(cnt_out), 9);
                check("pre_wrap_pending", int'(pending), 1);
                step_n(1);
                check("post_wrap_pending", int'(pending), 0);
                check("post_wrap_cnt", int'(cnt_out), 0);
                wait_drain(100);
                en = 1'b0;
                step_n(2);

                // prescaler: one tick every 3 clocks
                start_load(1, 1, 2);
                step_n(1);
                push_periods(6, 3, 3);
                en = 1'b1;
                step_n(2);
                check("presc_cnt_e2", int'(cnt_out), 0);
                step_n(1);
                check("presc_cnt_e3", int'(cnt_out), 1);
                step_n(3);
                check("presc_cnt_e6", int'(cnt_out), 0);
                wait_drain(100);
                en = 1'b0;
                step_n(2);

                // duty 0 and duty above period; pending copied when disabled
                start_load(99, 0, 0);
                step_n(1);
                push_periods(100, 0, 2);
                en = 1'b1;
                wait_drain(400);
                start_load(99, 200, 0);
                step_n(1);
                check("run_load_pending", int'(pending), 1);
                en = 1'b0;
                step_n(1);
                check("disable_copy_pending", int'(pending), 0);
                check("disable_cnt", int'(cnt_out), 0);
                push_periods(100, 100, 2);
                en = 1'b1;
                wait_drain(400);
                en = 1'b0;
                step_n(2);

                // double load in one period, then load coincident with wrap
                start_load(7, 2, 0);
                step_n(1);
                push_periods(8, 2, 1);
                push_periods(8, 6, 1);
                push_periods(8, 5, 1);
                push_periods(8, 3, 2);
                en = 1'b1;
                step_n(1);
                start_load(7, 4, 0);
                step_n(2);
                start_load(7, 6, 0);
                step_n(7);
                start_load(7, 5, 0);
                step_n(5);
                start_load(7, 3, 0);
                step_n(1);
                check("wrap_load_pending", int'(pending), 1);
                check("wrap_load_cnt", int'(cnt_out), 0);
                step_n(8);
                check("wrap_load_applied", int'(pending), 0);
                wait_drain(100);
                en = 1'b0;
                step_n(2);

                // asynchronous reset mid-period
                start_load(9, 7, 0);
                step_n(1);
                en = 1'b1;
                step_n(3);
                start_load(9, 2, 0);
                step_n(2);
                check("pre_rst_cnt", int'(cnt_out), 5);
                check("pre_rst_pending", int'(pending), 1);
                check("pre_rst_pwm", int'(pwm_out), 1);
                #2;
                rst = 1'b1;
                en  = 1'b0;
                #1;
                check("async_rst_pwm", int'(pwm_out), 0);
                check("async_rst_period_end", int'(period_end), 0);
                check("async_rst_pending", int'(pending), 0);
                check("async_rst_cnt", int'(cnt_out), 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                start_load(3, 1, 1);
                step_n(1);
                check("post_rst_load_pending", int'(pending), 0);
                push_periods(8, 2, 2);
                en = 1'b1;
                wait_drain(100);
                en = 1'b0;
                step_n(2);
            end
        join_any
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
